mem_responder: RTL and testbench

Memory-side responder for the single-port `ioMem` request interface that the pipeline fetch and load/store units drive. It holds a doubleword-wide synchronous RAM model and services one read or write request at a time. Each response arrives after a programmable fixed latency and is signalled by a one-cycle done pulse. It sits between the IFU/LSU request ports and the simulated main memory region at 0x8000_0000.

---
 rtl/mem_responder.sv | 202 ++++++++++++++++++++
 tb/tb_mem_responder.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//
// Memory-side responder for the single-port ioMem request interface driven by
// the fetch and load/store units. Holds a doubleword-wide RAM model and services
// one read or write at a time. The response comes back after a fixed, programmable
// latency and is flagged by a one-cycle done pulse.
//
// Optional feature (compile-time macro MEM_ADDR_CHECK_EN):
//   defined   - requests outside [BASE_ADDR, BASE_ADDR + 8*2^DEPTH_LOG2) complete
//               with ioMem_err=1; writes are dropped and reads return
//               64'hDEAD_BEEF_DEAD_BEEF.
//   undefined - ioMem_err is constant 0 and out-of-range addresses alias modulo
//               the RAM size.
//
// Parameters:
//   DEPTH_LOG2  log2 of the number of 64-bit words
//   BASE_ADDR   byte address of word 0
//   LATENCY     cycles from acceptance edge to done pulse (1..15)
//
// Ports:
//   clock        system clock, rising edge
//   reset        synchronous, active-high reset
//   ioMem_ren    read request
//   ioMem_wen    write request (ren and wen together: write-first)
//   ioMem_addr   byte address, bits [2:0] ignored
//   ioMem_wMask  byte enables, bit i covers lane [8i+7:8i]
//   ioMem_wData  write data
//   ioMem_ready  request can be accepted this cycle
//   ioMem_done   one-cycle completion pulse (reads and writes)
//   ioMem_rData  read data, valid with done, held until the next read completes
//   ioMem_err    access fault, qualified by done
// -----------------------------------------------------------------------------
module mem_responder #(
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int unsigned LATENCY    = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ioMem_ren,
    input  logic        ioMem_wen,
    input  logic [31:0] ioMem_addr,
    input  logic [7:0]  ioMem_wMask,
    input  logic [63:0] ioMem_wData,
    output logic        ioMem_ready,
    output logic        ioMem_done,
    output logic [63:0] ioMem_rData,
    output logic        ioMem_err
);

    localparam int unsigned Words     = 1 << DEPTH_LOG2;
    localparam logic [3:0]  WaitInit  = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;
    localparam logic [63:0] FaultData = 64'hDEAD_BEEF_DEAD_BEEF;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StWait = 2'b01,
        StResp = 2'b10
    } state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        ready_q;
    logic        done_q;
    logic [63:0] rdata_q;
    logic        err_q;
    logic [63:0] hold_q;      // word captured at acceptance, released in RESP
    logic        rd_q;        // pending request includes a read
    logic        err_pend_q;  // pending request was out of range

    logic [63:0] mem_q [Words];

    logic [31:0]           offset;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic                  in_range;
    logic                  accept;
    logic [63:0]           lane_mask;
    logic [63:0]           merged;
    logic [63:0]           read_word;

    // Offset wraps modulo 2^32; only the word-index bits select the RAM entry.
    assign offset   = ioMem_addr - BASE_ADDR;
    assign word_idx = offset[DEPTH_LOG2+2:3];

    logic unused_offset;
    assign unused_offset = ^offset;

`ifdef MEM_ADDR_CHECK_EN
    // 33-bit compare so a region ending exactly at 2^32 is still handled.
    localparam logic [32:0] LimitAddr = {1'b0, BASE_ADDR} + (33'd8 << DEPTH_LOG2);
    assign in_range = ({1'b0, ioMem_addr} >= {1'b0, BASE_ADDR}) &&
                      ({1'b0, ioMem_addr} < LimitAddr);
`else
    assign in_range = 1'b1;
`endif

    assign accept = ready_q && (ioMem_ren || ioMem_wen) && !reset;

    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < 8; i++) begin
            lane_mask[8*i +: 8] = {8{ioMem_wMask[i]}};
        end
    end

    assign merged = (mem_q[word_idx] & ~lane_mask) | (ioMem_wData & lane_mask);

    // Write-first: a combined read sees the post-write word.
    always_comb begin
        read_word = mem_q[word_idx];
        if (!in_range) begin
            read_word = FaultData;
        end else if (ioMem_wen) begin
            read_word = merged;
        end
    end

    // RAM contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (accept && ioMem_wen && in_range) begin
            mem_q[word_idx] <= merged;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            rdata_q    <= 64'h0;
            err_q      <= 1'b0;
            hold_q     <= 64'h0;
            rd_q       <= 1'b0;
            err_pend_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                    if (accept) begin
                        ready_q    <= 1'b0;
                        hold_q     <= read_word;
                        rd_q       <= ioMem_ren;
                        err_pend_q <= !in_range;
                        if (LATENCY <= 1) begin
                            // Response goes out directly in the next cycle.
                            state_q <= StResp;
                            done_q  <= 1'b1;
                            err_q   <= !in_range;
                            if (ioMem_ren) begin
                                rdata_q <= read_word;
                            end
                        end else begin
                            state_q <= StWait;
                            cnt_q   <= WaitInit;
                        end
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                StWait: begin
                    ready_q <= 1'b0;
                    if (cnt_q == 4'd0) begin
                        state_q <= StResp;
                        done_q  <= 1'b1;
                        err_q   <= err_pend_q;
                        if (rd_q) begin
                            rdata_q <= hold_q;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                    ready_q <= 1'b1;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                end
                default: begin
                    state_q    <= StIdle;
                    cnt_q      <= 4'd0;
                    ready_q    <= 1'b1;
                    done_q     <= 1'b0;
                    rdata_q    <= 64'h0;
                    err_q      <= 1'b0;
                    hold_q     <= 64'h0;
                    rd_q       <= 1'b0;
                    err_pend_q <= 1'b0;
                end
            endcase
        end
    end

    assign ioMem_ready = ready_q;
    assign ioMem_done  = done_q;
    assign ioMem_rData = rdata_q;
    assign ioMem_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
//
// Three responders with LATENCY 1, 4 and 3 share one clock and reset. Expected
// values come from a vector table and from a word-indexed reference memory.
// Honours MEM_ADDR_CHECK_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_mem_responder;

    localparam logic [31:0] Base  = 32'h8000_0000;
    localparam logic [63:0] Fault = 64'hDEAD_BEEF_DEAD_BEEF;
    localparam int          Lat [3] = '{1, 4, 3};

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic        ren   [3];
    logic        wen   [3];
    logic [31:0] addr  [3];
    logic [7:0]  wmask [3];
    logic [63:0] wdata [3];
    logic        ready [3];
    logic        done  [3];
    logic [63:0] rdata [3];
    logic        err   [3];

    mem_responder #(.DEPTH_LOG2(12), .BASE_ADDR(Base), .LATENCY(1)) u_l1 (
        .clock(clock), .reset(reset),
        .ioMem_ren(ren[0]), .ioMem_wen(wen[0]), .ioMem_addr(addr[0]),
        .ioMem_wMask(wmask[0]), .ioMem_wData(wdata[0]),
        .ioMem_ready(ready[0]), .ioMem_done(done[0]),
        .ioMem_rData(rdata[0]), .ioMem_err(err[0])
    );

    mem_responder #(.DEPTH_LOG2(12), .BASE_ADDR(Base), .LATENCY(4)) u_l4 (
        .clock(clock), .reset(reset),
        .ioMem_ren(ren[1]), .ioMem_wen(wen[1]), .ioMem_addr(addr[1]),
        .ioMem_wMask(wmask[1]), .ioMem_wData(wdata[1]),
        .ioMem_ready(ready[1]), .ioMem_done(done[1]),
        .ioMem_rData(rdata[1]), .ioMem_err(err[1])
    );

    mem_responder #(.DEPTH_LOG2(12), .BASE_ADDR(Base), .LATENCY(3)) u_l3 (
        .clock(clock), .reset(reset),
        .ioMem_ren(ren[2]), .ioMem_wen(wen[2]), .ioMem_addr(addr[2]),
        .ioMem_wMask(wmask[2]), .ioMem_wData(wdata[2]),
        .ioMem_ready(ready[2]), .ioMem_done(done[2]),
        .ioMem_rData(rdata[2]), .ioMem_err(err[2])
    );

    int nchk = 0;
    int nerr = 0;

    // Reference memory keyed by dut*65536 + word index; plus each DUT's held rData.
    logic [63:0] mdl [int];
    logic [63:0] last_rd [3];

    typedef struct {
        bit          r;
        bit          w;
        logic [31:0] a;
        logic [7:0]  m;
        logic [63:0] wd;
        logic [63:0] exp_rd;
        bit          exp_err;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    function automatic bit model_in_range(input logic [31:0] a);
`ifdef MEM_ADDR_CHECK_EN
        return (a >= Base) && ((a - Base) < 32'h8000);
`else
        return 1'b1;
`endif
    endfunction

    function automatic int key(input int d, input logic [31:0] a);
        logic [31:0] off;
        off = a - Base;
        return d * 65536 + int'((off >> 3) % 4096);
    endfunction

    function automatic logic [63:0] lanes(input logic [63:0] old, input logic [7:0] m,
                                          input logic [63:0] wd);
        logic [63:0] res;
        res = old;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) res[8*i +: 8] = wd[8*i +: 8];
        end
        return res;
    endfunction

    // Applies one request to the reference model and returns what the DUT must show.
    task automatic run_model(input int d, input bit r, input bit w, input logic [31:0] a,
                             input logic [7:0] m, input logic [63:0] wd,
                             output logic [63:0] exp_rd, output bit exp_err);
        bit ok;
        int k;
        logic [63:0] old;
        ok = model_in_range(a);
        k  = key(d, a);
        if (w && ok) begin
            old    = mdl.exists(k) ? mdl[k] : 64'hx;
            mdl[k] = lanes(old, m, wd);
        end
        if (r) last_rd[d] = ok ? mdl[k] : Fault;
        exp_rd  = last_rd[d];
        exp_err = !ok;
    endtask

    // Issues one request and checks ready/done every cycle up to the return of ready.
    task automatic req(input int d, input bit r, input bit w, input logic [31:0] a,
                       input logic [7:0] m, input logic [63:0] wd,
                       input logic [63:0] exp_rd, input bit exp_err, input string nm);
        int waited;
        waited = 0;
        @(negedge clock);
        while (!ready[d] && waited < 50) begin
            @(negedge clock);
            waited++;
        end
        if (!ready[d]) begin
            chk($sformatf("%s d%0d ready timeout", nm, d), {63'd0, ready[d]}, 64'd1);
            return;
        end
        ren[d] = r; wen[d] = w; addr[d] = a; wmask[d] = m; wdata[d] = wd;
        @(posedge clock); #1;
        ren[d] = 1'b0; wen[d] = 1'b0;
        for (int k = 1; k <= Lat[d] + 1; k++) begin
            chk($sformatf("%s d%0d cyc%0d ready,done", nm, d, k),
                {62'd0, ready[d], done[d]},
                {62'd0, k == Lat[d] + 1, k == Lat[d]});
            if (k == Lat[d]) begin
                chk($sformatf("%s d%0d rData", nm, d), rdata[d], exp_rd);
                chk($sformatf("%s d%0d err", nm, d), {63'd0, err[d]}, {63'd0, exp_err});
            end
            if (k <= Lat[d]) begin
                @(posedge clock); #1;
            end
        end
    endtask

    task automatic run(input int d, input bit r, input bit w, input logic [31:0] a,
                       input logic [7:0] m, input logic [63:0] wd, input string nm);
        logic [63:0] e_rd;
        bit e_err;
        run_model(d, r, w, a, m, wd, e_rd, e_err);
        req(d, r, w, a, m, wd, e_rd, e_err, nm);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] e_rd, va, vb, v;
        bit e_err;
        int sel, op;
        logic [31:0] a;

        for (int d = 0; d < 3; d++) begin
            ren[d] = 1'b0; wen[d] = 1'b0; addr[d] = '0; wmask[d] = '0; wdata[d] = '0;
            last_rd[d] = 64'h0;
        end

        tbl[0] = '{1'b0, 1'b1, 32'h8000_0010, 8'hFF, 64'h1122_3344_5566_7788,
                   64'h0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 32'h8000_0014, 8'h00, 64'h0,
                   64'h1122_3344_5566_7788, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 32'h8000_0010, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB,
                   64'h1122_3344_BBBB_BBBB, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 32'h8000_0100, 8'hFF, 64'h0123_4567_89AB_CDEF,
                   64'h1122_3344_BBBB_BBBB, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 32'h8000_0100, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF,
                   64'h1122_3344_BBBB_BBBB, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 32'h8000_0107, 8'h00, 64'h0,
                   64'h0123_4567_89AB_CDEF, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 32'h8000_0100, 8'h81, 64'hEE00_0000_0000_00DD,
                   64'hEE23_4567_89AB_CDDD, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 32'h8000_0010, 8'h00, 64'h0,
                   64'h1122_3344_BBBB_BBBB, 1'b0};

        // Reset release, then five idle cycles on every instance.
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clock); #1;
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("idle c%0d d%0d ready,done,err", c, d),
                    {61'd0, ready[d], done[d], err[d]}, 64'd4);
                chk($sformatf("idle c%0d d%0d rData", c, d), rdata[d], 64'h0);
            end
        end

        // Vector table on the LATENCY=1 instance.
        for (int i = 0; i < 8; i++) begin
            run_model(0, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].m, tbl[i].wd, e_rd, e_err);
            req(0, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].m, tbl[i].wd,
                tbl[i].exp_rd, tbl[i].exp_err, $sformatf("tbl%0d", i));
        end

        // Randomized traffic against the reference memory (LATENCY 1 and 4).
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 8; k++) begin
                run(d, 1'b0, 1'b1, Base + 32'(k * 8), 8'hFF, {$urandom, $urandom}, "fill");
            end
            for (int n = 0; n < 30; n++) begin
                sel = int'($urandom_range(0, 15));
                a = (sel < 8) ? Base + 32'(sel * 8) : Base + 32'h8000 + 32'((sel - 8) * 8);
                a = a + 32'($urandom_range(0, 7));
                op = int'($urandom_range(1, 3));
                run(d, op[0], op[1], a, 8'($urandom), {$urandom, $urandom},
                    $sformatf("rnd%0d", n));
            end
        end

        // LATENCY=4: second read held high during busy cycles is taken only once ready returns.
        va = mdl[key(1, Base)];
        vb = mdl[key(1, Base + 32'h8)];
        @(negedge clock);
        ren[1] = 1'b1; addr[1] = Base;
        @(posedge clock); #1;
        for (int k = 1; k <= 10; k++) begin
            chk($sformatf("busy cyc%0d ready,done", k), {62'd0, ready[1], done[1]},
                {62'd0, (k == 5 || k == 10), (k == 4 || k == 9)});
            if (k == 4) chk("busy first rData", rdata[1], va);
            if (k == 9) chk("busy second rData", rdata[1], vb);
            if (k == 1) addr[1] = Base + 32'h8;
            if (k == 6) ren[1] = 1'b0;
            if (k < 10) begin
                @(posedge clock); #1;
            end
        end
        last_rd[1] = vb;

        // LATENCY=3: reset right after accepting a read-with-write.
        run(2, 1'b0, 1'b1, Base + 32'h40, 8'hFF, 64'h0BAD_F00D_1234_5678, "pre w");
        run(2, 1'b1, 1'b0, Base + 32'h40, 8'h00, 64'h0, "pre r");
        v = 64'h5A5A_0F0F_C3C3_9696;
        @(negedge clock);
        ren[2] = 1'b1; wen[2] = 1'b1; addr[2] = Base + 32'h48; wmask[2] = 8'hFF; wdata[2] = v;
        @(posedge clock); #1;
        ren[2] = 1'b0; wen[2] = 1'b0;
        chk("rst accepted done", {63'd0, done[2]}, 64'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clock); #1;
            chk($sformatf("rst c%0d ready,done,err", k), {61'd0, ready[2], done[2], err[2]},
                64'd4);
            chk($sformatf("rst c%0d rData", k), rdata[2], 64'h0);
        end
        mdl[key(2, Base + 32'h48)] = v;
        for (int d = 0; d < 3; d++) last_rd[d] = 64'h0;
        run(2, 1'b1, 1'b0, Base + 32'h48, 8'h00, 64'h0, "rst committed");

        // Address range handling on the LATENCY=1 instance.
        run(0, 1'b0, 1'b1, Base, 8'hFF, 64'hCAFE_BABE_0000_1111, "w0 set");
`ifdef MEM_ADDR_CHECK_EN
        run_model(0, 1'b1, 1'b0, 32'h7FFF_FFF8, 8'h00, 64'h0, e_rd, e_err);
        req(0, 1'b1, 1'b0, 32'h7FFF_FFF8, 8'h00, 64'h0, Fault, 1'b1, "oor read");
        run_model(0, 1'b0, 1'b1, 32'h8000_8000, 8'hFF, 64'h5555_6666_7777_8888, e_rd, e_err);
        req(0, 1'b0, 1'b1, 32'h8000_8000, 8'hFF, 64'h5555_6666_7777_8888, Fault, 1'b1,
            "oor write");
        run_model(0, 1'b1, 1'b0, Base, 8'h00, 64'h0, e_rd, e_err);
        req(0, 1'b1, 1'b0, Base, 8'h00, 64'h0, 64'hCAFE_BABE_0000_1111, 1'b0, "w0 kept");
`else
        run_model(0, 1'b0, 1'b1, 32'h8000_8000, 8'hFF, 64'h5555_6666_7777_8888, e_rd, e_err);
        req(0, 1'b0, 1'b1, 32'h8000_8000, 8'hFF, 64'h5555_6666_7777_8888, e_rd, 1'b0,
            "alias write");
        run_model(0, 1'b1, 1'b0, Base, 8'h00, 64'h0, e_rd, e_err);
        req(0, 1'b1, 1'b0, Base, 8'h00, 64'h0, 64'h5555_6666_7777_8888, 1'b0, "w0 aliased");
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
